wb_stage: RTL
=============

Name: wb_stage

Overview:
Writeback stage of the 5-stage RV32IM pipeline. It holds the MEM/WB pipeline register, aligns and extends load data from the synchronous data memory, and selects the writeback source. It merges results from the long-latency mul/div unit into the single register-file write port, using a one-entry hold buffer and a pipeline stall. It drives the register-file write port and the same-cycle forwarding bus; the register file has no internal write-through.

Parameters:
XLEN, 32, datapath width
NOP_BUBBLE, 1'b0, valid value loaded into the WB register on reset

Ports:
clk_i  in  1  clock
rst_i  in  1  synchronous active-high reset
mem_valid_i  in  1  MEM stage holds a valid instruction
mem_rd_i  in  5  destination register
mem_wen_i  in  1  instruction writes rd
mem_wb_sel_i  in  2  0=ALU, 1=LOAD, 2=PC+4, 3=CSR
mem_funct3_i  in  3  load type
mem_addr_lo_i  in  2  load byte address [1:0]
mem_alu_i  in  32  ALU result
mem_pc4_i  in  32  PC+4
mem_csr_i  in  32  CSR read data
dmem_rdata_i  in  32  sync DMEM read word, valid in the instruction's first WB cycle only
lu_valid_i  in  1  mul/div result offered
lu_rd_i  in  5  mul/div destination
lu_data_i  in  32  mul/div result
lu_ready_o  out  1  mul/div result accepted this cycle
stall_o  out  1  freeze IF..MEM and the WB register
rf_wen_o  out  1  register-file write enable
rf_waddr_o  out  5  register-file write address
rf_wdata_o  out  32  register-file write data
fwd_valid_o  out  1  equals rf_wen_o
fwd_rd_o  out  5  equals rf_waddr_o
fwd_data_o  out  32  equals rf_wdata_o

Behaviour:
- WB register (valid, rd, wen, wb_sel, funct3, addr_lo, alu, pc4, csr) loads from the mem_* inputs on a rising edge when stall_o=0. When stall_o=1 it holds its value.
- first_q is set on each WB register load and cleared after one cycle. When first_q=1, formatted load data is computed from dmem_rdata_i and captured into ld_q. When first_q=0, ld_q is used.
- Load formatting:
  - LB/LBU (funct3 0/4): byte addr_lo, sign/zero-extended.
  - LH/LHU (funct3 1/5): half addr_lo[1], sign/zero-extended.
  - LW and any other funct3: full word.
- wb_need = valid & wen & (rd != 0).
- Hold buffer (hold_v, hold_rd, hold_data) write priority each cycle:
  1. If hold_v: write the hold entry and clear hold_v. stall_o=1 and lu_ready_o=0. The WB instruction does not write this cycle and stays frozen.
  2. Else if wb_need: write the WB instruction. lu_ready_o=1. If lu_valid_i, capture the lu result into hold and set hold_v.
  3. Else if lu_valid_i: write lu directly, lu_ready_o=1.
  4. Else: rf_wen_o=0.
- stall_o = hold_v (combinational from state).
- lu results with lu_rd_i=0 are accepted (lu_ready_o=1) and never written; they never enter hold.
- rf_wen_o is never 1 with rf_waddr_o=0.
- Forwarding outputs mirror the write port exactly, in the same cycle.
- Reset: WB valid=0, first_q=0, hold_v=0, ld_q=0. All outputs 0 except lu_ready_o, which follows the rules above (1 when hold is empty).
- Reset mid-operation drops any pending hold entry and the WB instruction with no write.
- Latency: a WB instruction writes in the cycle it enters WB unless hold_v is set, in which case it writes one cycle later. An lu result writes at most 2 cycles after acceptance.
- Upstream hazard detection against outstanding mul/div destinations lives in decode and is not part of this block.

Test Plan:
- ALU write: rd=5, wb_sel=0, alu=0x1234 -> next cycle rf_wen=1, waddr=5, wdata=0x1234, fwd mirrors.
- Loads: dmem=0x80FF7F01. LB addr_lo=1 -> 0x0000007F. LB addr_lo=3 -> 0xFFFFFF80. LHU addr_lo=2 -> 0x000080FF. LH addr_lo=2 -> 0xFFFF80FF. LW -> 0x80FF7F01.
- Collision: WB writes rd=3, lu_valid with rd=7, data=0xCAFE -> cycle N writes x3 with lu_ready=1. Cycle N+1: stall_o=1, writes x7=0xCAFE, and the next WB instruction (LB) is frozen. Change dmem_rdata_i during the stall -> the frozen load still writes its originally captured value at N+2.
- rd=0 suppression: WB rd=0 with lu_valid, rd=0 -> rf_wen=0, lu_ready=1, stall_o=0.
- Idle merge: WB bubble, lu_valid rd=9, data=0x55 -> same cycle rf_wen=1, waddr=9, wdata=0x55, no stall.
- Reset with hold_v=1 -> next cycle stall_o=0, rf_wen=0, lu_ready=1, and no write of the held value.

Source files
------------

// File: rtl/wb_stage.sv
// rtl/wb_stage.sv - RV32IM writeback stage: MEM/WB register, load align, mul/div merge
module wb_stage #(
    parameter int   XLEN       = 32,
    parameter logic NOP_BUBBLE = 1'b0
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            mem_valid_i,
    input  logic [4:0]      mem_rd_i,
    input  logic            mem_wen_i,
    input  logic [1:0]      mem_wb_sel_i,
    input  logic [2:0]      mem_funct3_i,
    input  logic [1:0]      mem_addr_lo_i,
    input  logic [XLEN-1:0] mem_alu_i,
    input  logic [XLEN-1:0] mem_pc4_i,
    input  logic [XLEN-1:0] mem_csr_i,
    input  logic [XLEN-1:0] dmem_rdata_i,
    input  logic            lu_valid_i,
    input  logic [4:0]      lu_rd_i,
    input  logic [XLEN-1:0] lu_data_i,
    output logic            lu_ready_o,
    output logic            stall_o,
    output logic            rf_wen_o,
    output logic [4:0]      rf_waddr_o,
    output logic [XLEN-1:0] rf_wdata_o,
    output logic            fwd_valid_o,
    output logic [4:0]      fwd_rd_o,
    output logic [XLEN-1:0] fwd_data_o
);

    logic            valid_q;
    logic [4:0]      rd_q;
    logic            wen_q;
    logic [1:0]      wb_sel_q;
    logic [2:0]      funct3_q;
    logic [1:0]      addr_lo_q;
    logic [XLEN-1:0] alu_q;
    logic [XLEN-1:0] pc4_q;
    logic [XLEN-1:0] csr_q;
    logic            first_q;
    logic [XLEN-1:0] ld_q;
    logic            hold_v;
    logic [4:0]      hold_rd;
    logic [XLEN-1:0] hold_data;

    logic [7:0]      ld_byte;
    logic [15:0]     ld_half;
    logic [XLEN-1:0] ld_fmt;
    logic [XLEN-1:0] ld_data;
    logic [XLEN-1:0] wb_data;
    logic            wb_need;
    logic            lu_write;
    logic            capture;

    assign stall_o = hold_v;
    assign wb_need = valid_q & wen_q & (rd_q != 5'd0);
    assign lu_write = lu_valid_i & (lu_rd_i != 5'd0);

    assign ld_byte = dmem_rdata_i[{addr_lo_q, 3'b000} +: 8];
    assign ld_half = dmem_rdata_i[{addr_lo_q[1], 4'b0000} +: 16];

    always_comb begin
        ld_fmt = dmem_rdata_i;
        case (funct3_q)
            3'd0:    ld_fmt = {{(XLEN-8){ld_byte[7]}}, ld_byte};
            3'd4:    ld_fmt = {{(XLEN-8){1'b0}}, ld_byte};
            3'd1:    ld_fmt = {{(XLEN-16){ld_half[15]}}, ld_half};
            3'd5:    ld_fmt = {{(XLEN-16){1'b0}}, ld_half};
            default: ld_fmt = dmem_rdata_i;
        endcase
    end

    // DMEM data is only valid in the first WB cycle; later cycles replay ld_q.
    assign ld_data = first_q ? ld_fmt : ld_q;

    always_comb begin
        wb_data = alu_q;
        case (wb_sel_q)
            2'd0:    wb_data = alu_q;
            2'd1:    wb_data = ld_data;
            2'd2:    wb_data = pc4_q;
            default: wb_data = csr_q;
        endcase
    end

    always_comb begin
        rf_wen_o   = 1'b0;
        rf_waddr_o = 5'd0;
        rf_wdata_o = '0;
        lu_ready_o = 1'b0;
        capture    = 1'b0;
        if (hold_v) begin
            rf_wen_o   = 1'b1;
            rf_waddr_o = hold_rd;
            rf_wdata_o = hold_data;
        end else if (wb_need) begin
            rf_wen_o   = 1'b1;
            rf_waddr_o = rd_q;
            rf_wdata_o = wb_data;
            lu_ready_o = 1'b1;
            capture    = lu_write;
        end else begin
            lu_ready_o = 1'b1;
            if (lu_write) begin
                rf_wen_o   = 1'b1;
                rf_waddr_o = lu_rd_i;
                rf_wdata_o = lu_data_i;
            end
        end
        // A reset cycle kills whatever would have been written.
        if (rst_i) begin
            rf_wen_o   = 1'b0;
            rf_waddr_o = 5'd0;
            rf_wdata_o = '0;
            capture    = 1'b0;
        end
    end

    assign fwd_valid_o = rf_wen_o;
    assign fwd_rd_o    = rf_waddr_o;
    assign fwd_data_o  = rf_wdata_o;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            valid_q   <= NOP_BUBBLE;
            rd_q      <= 5'd0;
            wen_q     <= 1'b0;
            wb_sel_q  <= 2'd0;
            funct3_q  <= 3'd0;
            addr_lo_q <= 2'd0;
            alu_q     <= '0;
            pc4_q     <= '0;
            csr_q     <= '0;
            first_q   <= 1'b0;
            ld_q      <= '0;
            hold_v    <= 1'b0;
            hold_rd   <= 5'd0;
            hold_data <= '0;
        end else begin
            if (!hold_v) begin
                valid_q   <= mem_valid_i;
                rd_q      <= mem_rd_i;
                wen_q     <= mem_wen_i;
                wb_sel_q  <= mem_wb_sel_i;
                funct3_q  <= mem_funct3_i;
                addr_lo_q <= mem_addr_lo_i;
                alu_q     <= mem_alu_i;
                pc4_q     <= mem_pc4_i;
                csr_q     <= mem_csr_i;
                first_q   <= 1'b1;
            end else begin
                first_q   <= 1'b0;
            end
            if (first_q) begin
                ld_q <= ld_fmt;
            end
            if (hold_v) begin
                hold_v <= 1'b0;
            end else if (capture) begin
                hold_v    <= 1'b1;
                hold_rd   <= lu_rd_i;
                hold_data <= lu_data_i;
            end
        end
    end

endmodule
